// File: rtl/ysyx_23060201_wbu_if.sv
// Retire handshake between the EXU/LSU side (master) and the writeback unit (slave).
// Carries the retiring instruction's destination, source select and candidate results.
interface ysyx_23060201_wbu_if #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [GPR_ADDR_WIDTH-1:0] in_rd;
  logic                      in_rd_wen;
  logic [1:0]                in_sel;
  logic [DATA_WIDTH-1:0]     in_alu;
  logic [DATA_WIDTH-1:0]     in_snpc;
  logic [DATA_WIDTH-1:0]     in_csr;
  logic [2:0]                in_ld_funct3;
  logic [1:0]                in_ld_off;

  modport master (
    output in_valid, in_rd, in_rd_wen, in_sel, in_alu, in_snpc, in_csr,
           in_ld_funct3, in_ld_off,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_sel, in_alu, in_snpc, in_csr,
           in_ld_funct3, in_ld_off,
    output in_ready
  );
endinterface

// File: rtl/ysyx_23060201_wbu.sv
// Writeback unit: retires one instruction at a time, extends load data and drives the GPR write port.
// Define WBU_FWD_EN to add the fwd_busy/fwd_valid/fwd_rd/fwd_data hazard outputs for decode.
module ysyx_23060201_wbu #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_23060201_wbu_if.slave        wb_in,
  input  logic                      lsu_rvalid,
  input  logic [DATA_WIDTH-1:0]     lsu_rdata,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      commit
`ifdef WBU_FWD_EN
  ,
  output logic                      fwd_busy,
  output logic                      fwd_valid,
  output logic [GPR_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_LD = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_SNPC = 2'b10;
  localparam logic [1:0] SEL_CSR  = 2'b11;

  logic [1:0]                state;
  logic [GPR_ADDR_WIDTH-1:0] rd_q;
  logic                      rd_wen_q;
  logic [2:0]                funct3_q;
  logic [1:0]                off_q;

  logic                      idle;
  logic                      direct_we;
  logic                      load_we;
  logic [DATA_WIDTH-1:0]     src_data;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [DATA_WIDTH-1:0]     ld_data;

  assign idle           = (state == S_IDLE);
  assign wb_in.in_ready = idle & ~rst;

  // Writes to x0 or from non-writing instructions still retire, but never reach the GPR file.
  assign direct_we = wb_in.in_rd_wen & (|wb_in.in_rd);
  assign load_we   = rd_wen_q & (|rd_q);

  // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
  always_comb begin
    src_data = wb_in.in_alu;
    case (wb_in.in_sel)
      SEL_SNPC: src_data = wb_in.in_snpc;
      SEL_CSR:  src_data = wb_in.in_csr;
      default:  src_data = wb_in.in_alu;
    endcase
  end

  always_comb begin
    ld_byte = lsu_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = lsu_rdata[15:8];
      2'd2:    ld_byte = lsu_rdata[23:16];
      2'd3:    ld_byte = lsu_rdata[31:24];
      default: ld_byte = lsu_rdata[7:0];
    endcase
    ld_half = off_q[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];

    ld_data = '0;
    case (funct3_q)
      3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b010:  ld_data = lsu_rdata;
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

  // NOTE: state and outputs are registers, so only non-blocking assignments are used here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      commit    <= 1'b0;
    end else begin
      gpr_wen <= 1'b0;
      commit  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_in.in_valid) begin
            rd_q     <= wb_in.in_rd;
            rd_wen_q <= wb_in.in_rd_wen;
            if (wb_in.in_sel == SEL_LOAD) begin
              funct3_q <= wb_in.in_ld_funct3;
              off_q    <= wb_in.in_ld_off;
              state    <= S_WAIT_LD;
            end else begin
              gpr_wen   <= direct_we;
              gpr_waddr <= wb_in.in_rd;
              gpr_wdata <= direct_we ? src_data : '0;
              commit    <= 1'b1;
              state     <= S_WRITE;
            end
          end
        end
        S_WAIT_LD: begin
          // No timeout: the load stays pending until memory answers or reset drops it.
          if (lsu_rvalid) begin
            gpr_wen   <= load_we;
            gpr_waddr <= rd_q;
            gpr_wdata <= load_we ? ld_data : '0;
            commit    <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WBU_FWD_EN
  assign fwd_busy  = (state == S_WAIT_LD) & load_we;
  assign fwd_valid = gpr_wen;
  assign fwd_rd    = rd_q;
  assign fwd_data  = gpr_wdata;
`endif

endmodule
